uart_frame_decoder: RTL

Sits directly downstream of the UART receiver. It consumes the receiver's byte/valid outputs and assembles framed command packets into two multiplier operands. Frame format: header byte, operand A (MSB byte first), operand B (MSB byte first), one XOR checksum byte. Good frames produce a one-cycle operand strobe toward the multiplier core; bad or stalled frames are discarded with an error pulse.

---
 rtl/uart_frame_decoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_decoder.sv
// Assembles header/operand-A/operand-B/XOR-checksum frames from a UART byte stream
// into multiplier operands, with checksum and inter-byte timeout rejection.
module uart_frame_decoder #(
    parameter int unsigned OPERAND_BYTES  = 2,
    parameter logic [7:0]  HEADER_BYTE    = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000
) (
    input  logic                       uart_clock,
    input  logic                       uart_reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [8*OPERAND_BYTES-1:0] op_a,
    output logic [8*OPERAND_BYTES-1:0] op_b,
    output logic                       op_valid,
    output logic                       chk_error,
    output logic                       timeout_error,
    output logic                       frame_busy
);

    localparam int unsigned W        = 8 * OPERAND_BYTES;
    localparam logic [1:0]  LAST_IDX = 2'(OPERAND_BYTES - 1);
    localparam logic [23:0] TIMER_TC = TIMEOUT_CYCLES - 24'd1;

    typedef enum logic [1:0] {
        IDLE,
        OPER_A,
        OPER_B,
        CHECK
    } state_t;

    state_t         state_q, state_d;
    logic           rx_valid_dly_q, rx_valid_dly_d;
    logic [23:0]    timer_q, timer_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     checksum_q, checksum_d;
    logic [W-1:0]   shadow_a_q, shadow_a_d;
    logic [W-1:0]   shadow_b_q, shadow_b_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic           op_valid_q, op_valid_d;
    logic           chk_error_q, chk_error_d;
    logic           timeout_error_q, timeout_error_d;
    logic           byte_stb;

    // rx_valid is a level; only its rising edge delivers a new byte.
    assign byte_stb = rx_valid & ~rx_valid_dly_q;

    always_comb begin
        state_d         = state_q;
        rx_valid_dly_d  = rx_valid;
        timer_d         = timer_q;
        byte_cnt_d      = byte_cnt_q;
        checksum_d      = checksum_q;
        shadow_a_d      = shadow_a_q;
        shadow_b_d      = shadow_b_q;
        op_a_d          = op_a_q;
        op_b_d          = op_b_q;
        op_valid_d      = 1'b0;
        chk_error_d     = 1'b0;
        timeout_error_d = 1'b0;

        if (byte_stb) begin
            timer_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_data == HEADER_BYTE) begin
                        state_d    = OPER_A;
                        byte_cnt_d = '0;
                        checksum_d = '0;
                    end
                end
                OPER_A: begin
                    shadow_a_d = W'({shadow_a_q, rx_data});
                    checksum_d = checksum_q ^ rx_data;
                    if (byte_cnt_q == LAST_IDX) begin
                        byte_cnt_d = '0;
                        state_d    = OPER_B;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
                OPER_B: begin
                    shadow_b_d = W'({shadow_b_q, rx_data});
                    checksum_d = checksum_q ^ rx_data;
                    if (byte_cnt_q == LAST_IDX) begin
                        byte_cnt_d = '0;
                        state_d    = CHECK;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
                CHECK: begin
                    if (rx_data == checksum_q) begin
                        op_a_d     = shadow_a_q;
                        op_b_d     = shadow_b_q;
                        op_valid_d = 1'b1;
                    end else begin
                        chk_error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A byte on the terminal-count cycle takes the branch above instead.
            if (timer_q == TIMER_TC) begin
                state_d         = IDLE;
                timeout_error_d = 1'b1;
                timer_d         = '0;
            end else begin
                timer_d = timer_q + 24'd1;
            end
        end
    end

    always_ff @(posedge uart_clock or posedge uart_reset) begin
        if (uart_reset) begin
            state_q         <= IDLE;
            rx_valid_dly_q  <= 1'b1;
            timer_q         <= '0;
            byte_cnt_q      <= '0;
            checksum_q      <= '0;
            shadow_a_q      <= '0;
            shadow_b_q      <= '0;
            op_a_q          <= '0;
            op_b_q          <= '0;
            op_valid_q      <= 1'b0;
            chk_error_q     <= 1'b0;
            timeout_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_valid_dly_q  <= rx_valid_dly_d;
            timer_q         <= timer_d;
            byte_cnt_q      <= byte_cnt_d;
            checksum_q      <= checksum_d;
            shadow_a_q      <= shadow_a_d;
            shadow_b_q      <= shadow_b_d;
            op_a_q          <= op_a_d;
            op_b_q          <= op_b_d;
            op_valid_q      <= op_valid_d;
            chk_error_q     <= chk_error_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign op_valid      = op_valid_q;
    assign chk_error     = chk_error_q;
    assign timeout_error = timeout_error_q;
    assign frame_busy    = (state_q != IDLE);

endmodule
